ex_muldiv_sequencer: RTL and testbench
======================================

// Module: ex_muldiv_sequencer
// PURPOSE
//  Multi-cycle multiply/divide sequencer beside the EX-stage ALU. Runs MIPS mult/multu/div/divu
//  iteratively (1 bit/cycle), owns the HI/LO registers and services mthi/mtlo.
//  Raises Stall to hold IF/ID/EX while a dependent instruction waits on a busy unit.
//  ALU and ALUControl unchanged; this block observes the same ALUFunction/operand buses.
// PARAMETERS
//  NBits  32  operand/HI/LO width; iteration counter is $clog2(NBits) bits
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-low reset
//  Start        in   1      level: EX holds an R-type muldiv/mthi/mtlo/mfhi/mflo instruction
//  ALUFunction  in   6      funct field: 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu,
//                           0x10 mfhi, 0x11 mthi, 0x12 mflo, 0x13 mtlo
//  OperandA     in   NBits  rs value (multiplicand/dividend; mthi/mtlo data)
//  OperandB     in   NBits  rt value (multiplier/divisor)
//  Flush        in   1      abort in-flight op (branch/jump squash of this instruction)
//  Busy         out  1      iteration or fix-up in progress
//  Done         out  1      one-cycle pulse: HI/LO just updated by mult/div
//  Stall        out  1      hold pipeline: Start & Busy
//  HI, LO       out  NBits  architectural HI/LO registers
// BEHAVIOUR
//  Reset (async, reset==0): state IDLE, counter 0, HI=LO=0, Busy=Done=Stall=0.
//  States: IDLE, MUL, DIV, FIX, DONE. Busy=1 in MUL/DIV/FIX only; Done=1 in DONE only.
//  IDLE/DONE + Start, funct 0x18/0x19 -> MUL; 0x1A/0x1B -> DIV; latch |A|,|B| for signed
//   ops (raw for unsigned); record result signs; counter=NBits-1.
//  IDLE/DONE + Start, 0x11/0x13: HI/LO <= OperandA at that edge; stay/return IDLE, no Done.
//  0x10/0x12 read HI/LO combinationally elsewhere; no state change.
//  MUL: shift-add, one multiplier bit per cycle; DIV: restoring, one quotient bit per cycle.
//  Counter decrements each cycle; at counter==0 -> FIX.
//  FIX: two's-complement negate product (sign A^B), quotient (A^B), remainder (sign A);
//   HI/LO written at edge leaving FIX -> DONE. DONE -> IDLE next cycle unless new Start.
//  Latency: Start accepted at edge E0; HI/LO valid and Done=1 in cycle E0+NBits+2 (34 @32).
//  Product: HI=upper, LO=lower NBits of 2*NBits result. Divide: LO=quotient, HI=remainder.
//  Start while Busy: ignored, Stall=1; instruction is held and accepted once IDLE/DONE.
//  Flush (any state) -> IDLE next edge, HI/LO unchanged, no Done; Flush beats same-cycle Start.
//  Reset mid-operation: immediate IDLE, HI=LO=0.
//  Unrecognised funct with Start: ignored, no state change.
// CONFIGURATION
//  MULDIV_DIVZERO_FAST_EN defined: div/divu with OperandB==0 skips DIV, goes straight
//   to DONE next edge: LO=all ones, HI=OperandA, Done pulses (latency 1 cycle).
//  Undefined: divide-by-zero runs the full restoring sequence; divu gives LO=all ones,
//   HI=OperandA; div gives the sign-fixed value of that result; latency NBits+2.
// TESTING
//  1 mult A=7, B=0xFFFFFFFD -> 34 cycles later Done=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
//  2 divu A=100, B=7 -> LO=14, HI=2; Busy high exactly 33 cycles.
//  3 div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  4 mthi 0x1234, then mult in flight, Flush at cycle 10 -> IDLE, HI=0x1234, no Done.
//  5 mflo held with Start during cycles 1..33 of a divu -> Stall=1 until DONE, then 0.
//  6 divu A=5, B=0 -> LO=0xFFFFFFFF, HI=5; Done after 1 cycle with _EN, after 34 without.
//  7 reset=0 asserted at cycle 20 of mult -> Busy=0, HI=LO=0 immediately, no Done.

Source files
------------

// File: rtl/ex_muldiv_sequencer_if.sv
// ex_muldiv_sequencer_if: EX-stage multiply/divide sequencer interface.
// The master (pipeline side) drives the instruction request and flush.
// The slave (sequencer) returns its status and the architectural HI/LO values.
interface ex_muldiv_sequencer_if #(
  parameter int NBits = 32
);
  logic             Start;
  logic [5:0]       ALUFunction;
  logic [NBits-1:0] OperandA;
  logic [NBits-1:0] OperandB;
  logic             Flush;
  logic             Busy;
  logic             Done;
  logic             Stall;
  logic [NBits-1:0] HI;
  logic [NBits-1:0] LO;

  modport master (
    output Start, ALUFunction, OperandA, OperandB, Flush,
    input  Busy, Done, Stall, HI, LO
  );

  modport slave (
    input  Start, ALUFunction, OperandA, OperandB, Flush,
    output Busy, Done, Stall, HI, LO
  );
endinterface

// File: rtl/ex_muldiv_sequencer.sv
// ex_muldiv_sequencer: iterative MIPS mult/multu/div/divu unit, one bit per cycle.
// It owns HI/LO, services mthi/mtlo and stalls dependent instructions while busy.
// Optional macro MULDIV_DIVZERO_FAST_EN: a divide by zero completes in one cycle
// with LO = all ones and HI = OperandA instead of running the full sequence.
module ex_muldiv_sequencer #(
  parameter int NBits = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  ex_muldiv_sequencer_if.slave  bus
);

  localparam int CntW = (NBits > 1) ? $clog2(NBits) : 1;
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(NBits - 1);

  localparam logic [5:0] FnMfhi  = 6'h10;
  localparam logic [5:0] FnMthi  = 6'h11;
  localparam logic [5:0] FnMflo  = 6'h12;
  localparam logic [5:0] FnMtlo  = 6'h13;
  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1A;
  localparam logic [5:0] FnDivu  = 6'h1B;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} stateT;

  stateT            stateReg,   stateNext;
  logic [CntW-1:0]  counterReg, counterNext;
  // accHi: product high half / partial remainder; accLo: multiplier / quotient
  logic [NBits-1:0] accHiReg,   accHiNext;
  logic [NBits-1:0] accLoReg,   accLoNext;
  // operand: multiplicand magnitude or divisor magnitude
  logic [NBits-1:0] operandReg, operandNext;
  logic             signQReg,   signQNext;   // sign of product / quotient (A^B)
  logic             signRReg,   signRNext;   // sign of remainder (A)
  logic             isDivReg,   isDivNext;
  logic [NBits-1:0] hiReg,      hiNext;
  logic [NBits-1:0] loReg,      loNext;

  // Datapath helpers for one iteration and for the final sign fix-up
  logic                 isSigned;
  logic [NBits-1:0]     absA, absB;
  logic [NBits:0]       mulSum;
  logic [NBits:0]       divShift;
  logic [NBits:0]       divDiff;
  logic                 divGeq;
  logic [NBits-1:0]     divRem;
  logic [2*NBits-1:0]   prodRaw, prodFix;
  logic [NBits-1:0]     quotFix, remFix;

  // Per-iteration arithmetic: shift-add step, restoring-divide step, sign fix-up
  always_comb begin
    isSigned = ~bus.ALUFunction[0];
    absA     = (isSigned && bus.OperandA[NBits-1]) ? -bus.OperandA : bus.OperandA;
    absB     = (isSigned && bus.OperandB[NBits-1]) ? -bus.OperandB : bus.OperandB;
    mulSum   = {1'b0, accHiReg} + (accLoReg[0] ? {1'b0, operandReg} : '0);
    divShift = {accHiReg, accLoReg[NBits-1]};
    divGeq   = divShift >= {1'b0, operandReg};
    divDiff  = divShift - {1'b0, operandReg};
    divRem   = divGeq ? divDiff[NBits-1:0] : divShift[NBits-1:0];
    prodRaw  = {accHiReg, accLoReg};
    prodFix  = signQReg ? -prodRaw : prodRaw;
    quotFix  = signQReg ? -accLoReg : accLoReg;
    remFix   = signRReg ? -accHiReg : accHiReg;
  end

  // Next-state and datapath-next logic; Flush overrides everything, HI/LO kept
  always_comb begin
    stateNext   = stateReg;
    counterNext = counterReg;
    accHiNext   = accHiReg;
    accLoNext   = accLoReg;
    operandNext = operandReg;
    signQNext   = signQReg;
    signRNext   = signRReg;
    isDivNext   = isDivReg;
    hiNext      = hiReg;
    loNext      = loReg;

    case (stateReg)
      IDLE, DONE: begin
        stateNext = IDLE;
        if (bus.Start) begin
          case (bus.ALUFunction)
            FnMult, FnMultu, FnDiv, FnDivu: begin
              accHiNext   = '0;
              accLoNext   = absA;
              operandNext = absB;
              signQNext   = isSigned & (bus.OperandA[NBits-1] ^ bus.OperandB[NBits-1]);
              signRNext   = isSigned & bus.OperandA[NBits-1];
              isDivNext   = bus.ALUFunction[1];
              counterNext = CntLast;
              stateNext   = bus.ALUFunction[1] ? DIV : MUL;
`ifdef MULDIV_DIVZERO_FAST_EN
              if (bus.ALUFunction[1] && (bus.OperandB == '0)) begin
                hiNext    = bus.OperandA;
                loNext    = '1;
                stateNext = DONE;
              end
`endif
            end
            FnMthi: hiNext = bus.OperandA;
            FnMtlo: loNext = bus.OperandA;
            // mfhi/mflo read HI/LO outside this block; others are not ours
            FnMfhi, FnMflo: ;
            default: ;
          endcase
        end
      end
      MUL: begin
        accHiNext   = mulSum[NBits:1];
        accLoNext   = {mulSum[0], accLoReg[NBits-1:1]};
        counterNext = counterReg - CntOne;
        if (counterReg == '0) stateNext = FIX;
      end
      DIV: begin
        accHiNext   = divRem;
        accLoNext   = {accLoReg[NBits-2:0], divGeq};
        counterNext = counterReg - CntOne;
        if (counterReg == '0) stateNext = FIX;
      end
      FIX: begin
        if (isDivReg) begin
          hiNext = remFix;
          loNext = quotFix;
        end else begin
          hiNext = prodFix[2*NBits-1:NBits];
          loNext = prodFix[NBits-1:0];
        end
        stateNext = DONE;
      end
      default: stateNext = IDLE;
    endcase

    if (bus.Flush) begin
      stateNext = IDLE;
      hiNext    = hiReg;
      loNext    = loReg;
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg   <= IDLE;
      counterReg <= '0;
      accHiReg   <= '0;
      accLoReg   <= '0;
      operandReg <= '0;
      signQReg   <= 1'b0;
      signRReg   <= 1'b0;
      isDivReg   <= 1'b0;
      hiReg      <= '0;
      loReg      <= '0;
    end else begin
      stateReg   <= stateNext;
      counterReg <= counterNext;
      accHiReg   <= accHiNext;
      accLoReg   <= accLoNext;
      operandReg <= operandNext;
      signQReg   <= signQNext;
      signRReg   <= signRNext;
      isDivReg   <= isDivNext;
      hiReg      <= hiNext;
      loReg      <= loNext;
    end
  end

  // Status outputs decoded from the state; Stall holds a waiting instruction
  always_comb begin
    bus.Busy  = (stateReg == MUL) || (stateReg == DIV) || (stateReg == FIX);
    bus.Done  = (stateReg == DONE);
    bus.Stall = bus.Start & bus.Busy;
    bus.HI    = hiReg;
    bus.LO    = loReg;
  end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// tb_ex_muldiv_sequencer: directed self-checking bench for ex_muldiv_sequencer.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ex_muldiv_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   lat;
  int   busyCnt;
  int   doneSeen;

  ex_muldiv_sequencer_if #(.NBits(32)) ifc ();

  ex_muldiv_sequencer #(.NBits(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present one instruction for one edge; returns in the cycle after acceptance
  task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    ifc.Start       = 1'b1;
    ifc.ALUFunction = fn;
    ifc.OperandA    = a;
    ifc.OperandB    = b;
    @(negedge clk);
    ifc.Start       = 1'b0;
  endtask

  // Cycles from acceptance until Done (cycle 1 is the one after acceptance), bounded
  task automatic runToDone(output int latency, output int busyCycles);
    latency    = 1;
    busyCycles = 0;
    while (ifc.Done !== 1'b1 && latency < 100) begin
      if (ifc.Busy === 1'b1) busyCycles++;
      @(negedge clk);
      latency++;
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    reset           = 1'b0;
    ifc.Start       = 1'b0;
    ifc.ALUFunction = 6'h00;
    ifc.OperandA    = '0;
    ifc.OperandB    = '0;
    ifc.Flush       = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy",  {63'd0, ifc.Busy},  64'd0);
    check("rst_done",  {63'd0, ifc.Done},  64'd0);
    check("rst_stall", {63'd0, ifc.Stall}, 64'd0);
    check("rst_hilo",  {ifc.HI, ifc.LO},   64'd0);
    reset = 1'b1;
    @(negedge clk);

    // 1: mult 7 * -3 = -21
    issue(6'h18, 32'd7, 32'hFFFF_FFFD);
    runToDone(lat, busyCnt);
    check("mult_lat",  lat,              34);
    check("mult_busy", busyCnt,          33);
    check("mult_hilo", {ifc.HI, ifc.LO}, 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);
    check("mult_done_pulse", {62'd0, ifc.Done, ifc.Busy}, 64'd0);

    // multu all-ones squared
    issue(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runToDone(lat, busyCnt);
    check("multu_hilo", {ifc.HI, ifc.LO}, 64'hFFFF_FFFE_0000_0001);

    // 2: divu 100 / 7
    issue(6'h1B, 32'd100, 32'd7);
    runToDone(lat, busyCnt);
    check("divu_lat",  lat,              34);
    check("divu_busy", busyCnt,          33);
    check("divu_hilo", {ifc.HI, ifc.LO}, {32'd2, 32'd14});

    // 3: div -7 / 2 -> q=-3, r=-1
    issue(6'h1A, 32'hFFFF_FFF9, 32'd2);
    runToDone(lat, busyCnt);
    check("div_neg_hilo", {ifc.HI, ifc.LO}, 64'hFFFF_FFFF_FFFF_FFFD);

    // div 7 / -2 -> q=-3, r=+1
    issue(6'h1A, 32'd7, 32'hFFFF_FFFE);
    runToDone(lat, busyCnt);
    check("div_negb_hilo", {ifc.HI, ifc.LO}, {32'd1, 32'hFFFF_FFFD});

    // 4: mthi/mtlo then flushed mult
    issue(6'h11, 32'h0000_1234, 32'd0);
    check("mthi_hi",   {32'd0, ifc.HI}, 64'h1234);
    check("mthi_idle", {62'd0, ifc.Busy, ifc.Done}, 64'd0);
    issue(6'h13, 32'h0000_0055, 32'd0);
    check("mtlo_lo",   {32'd0, ifc.LO}, 64'h55);
    issue(6'h18, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    check("flush_pre_busy", {63'd0, ifc.Busy}, 64'd1);
    ifc.Flush = 1'b1;
    @(negedge clk);
    ifc.Flush = 1'b0;
    check("flush_busy", {63'd0, ifc.Busy}, 64'd0);
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ifc.Done === 1'b1) doneSeen++;
      @(negedge clk);
    end
    check("flush_no_done", doneSeen, 0);
    check("flush_hilo", {ifc.HI, ifc.LO}, {32'h1234, 32'h55});

    // Flush wins over a same-cycle Start
    ifc.Flush = 1'b1;
    issue(6'h18, 32'd3, 32'd5);
    ifc.Flush = 1'b0;
    check("flush_beats_start", {62'd0, ifc.Busy, ifc.Done}, 64'd0);

    // Unrecognised funct is ignored
    issue(6'h20, 32'hDEAD_BEEF, 32'd1);
    check("bad_funct_state", {62'd0, ifc.Busy, ifc.Done}, 64'd0);
    check("bad_funct_hilo",  {ifc.HI, ifc.LO}, {32'h1234, 32'h55});

    // 5: mflo held behind a divu stalls until DONE
    issue(6'h1B, 32'd100, 32'd7);
    ifc.Start       = 1'b1;
    ifc.ALUFunction = 6'h12;
    for (int c = 1; c <= 34; c++) begin
      check($sformatf("stall_c%0d", c), {63'd0, ifc.Stall}, (c <= 33) ? 64'd1 : 64'd0);
      if (c < 34) @(negedge clk);
    end
    check("stall_done", {63'd0, ifc.Done}, 64'd1);
    @(negedge clk);
    ifc.Start = 1'b0;
    check("stall_after", {61'd0, ifc.Stall, ifc.Busy, ifc.Done}, 64'd0);
    check("stall_lo", {32'd0, ifc.LO}, 64'd14);

    // 6: divu by zero
    issue(6'h1B, 32'd5, 32'd0);
    runToDone(lat, busyCnt);
`ifdef MULDIV_DIVZERO_FAST_EN
    check("divz_lat", lat, 1);
`else
    check("divz_lat", lat, 34);
`endif
    check("divz_hilo", {ifc.HI, ifc.LO}, {32'd5, 32'hFFFF_FFFF});

    // 7: reset in the middle of a mult
    issue(6'h18, 32'd9, 32'd9);
    repeat (19) @(negedge clk);
    check("rstmid_pre_busy", {63'd0, ifc.Busy}, 64'd1);
    reset = 1'b0;
    #1;
    check("rstmid_busy", {62'd0, ifc.Busy, ifc.Done}, 64'd0);
    check("rstmid_hilo", {ifc.HI, ifc.LO}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ifc.Done === 1'b1 || ifc.Busy === 1'b1) doneSeen++;
      @(negedge clk);
    end
    check("rstmid_quiet", doneSeen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
